// File: rtl/pcm_sample_fifo.sv
// ---------------------------------------------------------------------------
// pcm_sample_fifo
//
// Stereo PCM elastic buffer between the YM3016 DAC-frame decoder and the
// SPDIF transmitter, both clocked from the single 24 MHz system clock.
// Frames are stored as {left,right} words in a 2^DEPTH_LOG2-entry circular
// buffer. After reset the buffer prefills to half depth (FILLING) before
// SPDIF requests are served (RUNNING). A request that finds the buffer empty
// counts an underflow and drops back to FILLING so the buffer can recentre.
//
// Ports
//   clk             system clock, 24 MHz domain
//   reset_n         synchronous active-low reset
//   in_valid        one-cycle strobe: new frame on in_left/in_right
//   in_left         left sample from the decoder   [SAMPLE_W]
//   in_right        right sample from the decoder  [SAMPLE_W]
//   frame_req       one-cycle strobe: SPDIF wants the next frame
//   clear_stats     strobe: zero both event counters (wins over events)
//   out_left        registered left sample to SPDIF  [SAMPLE_W]
//   out_right       registered right sample to SPDIF [SAMPLE_W]
//   level           occupancy in frames               [DEPTH_LOG2+1]
//   running         high while serving requests
//   overflow_count  saturating count of dropped input frames [16]
//   underflow_count saturating count of starved requests     [16]
// ---------------------------------------------------------------------------
module pcm_sample_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int SAMPLE_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [SAMPLE_W-1:0]   in_left,
  input  logic [SAMPLE_W-1:0]   in_right,
  input  logic                  frame_req,
  input  logic                  clear_stats,
  output logic [SAMPLE_W-1:0]   out_left,
  output logic [SAMPLE_W-1:0]   out_right,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  running,
  output logic [15:0]           overflow_count,
  output logic [15:0]           underflow_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] HALF_LVL = (DEPTH_LOG2+1)'(DEPTH / 2);

  typedef enum logic {
    FILLING = 1'b0,
    RUNNING = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [2*SAMPLE_W-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;

  logic                       full_p0;
  logic                       empty_p0;
  logic                       req_run_p0;
  logic                       push_p0;
  logic                       pop_p0;
  logic                       ovf_evt_p0;
  logic                       unf_evt_p0;
  logic signed [SAMPLE_W-1:0] head_left_p0;
  logic signed [SAMPLE_W-1:0] head_right_p0;

  // Event counters stick at all-ones rather than wrapping to zero.
  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  // ---- stage p0: request decode against the pre-edge occupancy ----
  // A pop frees a slot in the same cycle, so a push into a full buffer is
  // accepted when it coincides with a pop; only otherwise is it dropped.
  always_comb begin
    full_p0    = (level == FULL_LVL);
    empty_p0   = (level == '0);
    req_run_p0 = frame_req && (state_q == RUNNING);
    pop_p0     = req_run_p0 && !empty_p0;
    unf_evt_p0 = req_run_p0 && empty_p0;
    push_p0    = in_valid && (!full_p0 || pop_p0);
    ovf_evt_p0 = in_valid && full_p0 && !pop_p0;
  end

  // Head of queue; read before the same-edge write so a full-buffer
  // push/pop (wr_ptr == rd_ptr) returns the old frame.
  assign {head_left_p0, head_right_p0} = mem[rd_ptr];

  // FILLING waits for the registered level to reach half depth, so the
  // switch to RUNNING lands one cycle after the threshold is reached.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILLING: if (level >= HALF_LVL) state_d = RUNNING;
      RUNNING: if (unf_evt_p0)        state_d = FILLING;
      default:                        state_d = FILLING;
    endcase
  end

  // ---- stage p1: registered state, pointers, outputs and counters ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= FILLING;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      level           <= '0;
      out_left        <= '0;
      out_right       <= '0;
      overflow_count  <= '0;
      underflow_count <= '0;
    end else begin
      state_q <= state_d;

      if (push_p0) wr_ptr <= wr_ptr + 1'b1;

      if (pop_p0) begin
        rd_ptr    <= rd_ptr + 1'b1;
        out_left  <= head_left_p0;
        out_right <= head_right_p0;
      end

      case ({push_p0, pop_p0})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      if (clear_stats)     overflow_count <= '0;
      else if (ovf_evt_p0) overflow_count <= sat_inc(overflow_count);

      if (clear_stats)     underflow_count <= '0;
      else if (unf_evt_p0) underflow_count <= sat_inc(underflow_count);
    end
  end

  // Sample storage carries no reset; stale contents are unreachable once
  // the pointers and level are cleared.
  always_ff @(posedge clk) begin
    if (push_p0 && reset_n) mem[wr_ptr] <= {in_left, in_right};
  end

  assign running = (state_q == RUNNING);

endmodule

// File: tb/tb_pcm_sample_fifo.sv
// ---------------------------------------------------------------------------
// tb_pcm_sample_fifo
//
// Self-checking bench for pcm_sample_fifo (DEPTH_LOG2=4, SAMPLE_W=16).
// A queue-based reference tracks buffer contents, state and counters; frames
// popped by requests are pushed to a scoreboard queue and compared when the
// DUT presents them. A vector table covers prefill and ordering, followed by
// hand sequences for underflow, overflow, full-buffer push/pop with pointer
// wrap, clear/overflow coincidence, mid-stream reset and a random soak.
// ---------------------------------------------------------------------------
module tb_pcm_sample_fifo;

  localparam int DL = 4;
  localparam int SW = 16;
  localparam int DEPTH = 1 << DL;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic [SW-1:0] in_left;
  logic [SW-1:0] in_right;
  logic          frame_req;
  logic          clear_stats;
  logic [SW-1:0] out_left;
  logic [SW-1:0] out_right;
  logic [DL:0]   level;
  logic          running;
  logic [15:0]   overflow_count;
  logic [15:0]   underflow_count;

  pcm_sample_fifo #(
    .DEPTH_LOG2 (DL),
    .SAMPLE_W   (SW)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .in_valid        (in_valid),
    .in_left         (in_left),
    .in_right        (in_right),
    .frame_req       (frame_req),
    .clear_stats     (clear_stats),
    .out_left        (out_left),
    .out_right       (out_right),
    .level           (level),
    .running         (running),
    .overflow_count  (overflow_count),
    .underflow_count (underflow_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference state
  logic [31:0] m_fifo [$];
  logic [31:0] exp_q  [$];
  bit          m_run;
  int          m_ovf;
  int          m_unf;
  logic [31:0] m_out;

  typedef struct {
    bit          v;
    logic [15:0] l;
    logic [15:0] r;
    bit          req;
    int          lvl;
    bit          run;
    logic [31:0] out;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_fifo.delete();
    exp_q.delete();
    m_run = 1'b0;
    m_ovf = 0;
    m_unf = 0;
    m_out = '0;
  endtask

  task automatic check_all();
    chk("out", {out_left, out_right}, m_out);
    chk("level", 32'(level), 32'(m_fifo.size()));
    chk("running", 32'(running), 32'(m_run));
    chk("overflow_count", 32'(overflow_count), 32'(m_ovf));
    chk("underflow_count", 32'(underflow_count), 32'(m_unf));
  endtask

  // One clock of stimulus; the reference is advanced from the pre-edge view.
  task automatic step(input bit v, input logic [15:0] l, input logic [15:0] r,
                      input bit req, input bit clr);
    int pre;
    bit pop;
    in_valid    = v;
    in_left     = l;
    in_right    = r;
    frame_req   = req;
    clear_stats = clr;
    pre = m_fifo.size();
    pop = 1'b0;
    if (m_run && req) begin
      if (pre > 0) begin
        pop = 1'b1;
        exp_q.push_back(m_fifo.pop_front());
      end else if (m_unf < 65535) begin
        m_unf++;
      end
    end
    if (v) begin
      if (pre < DEPTH || pop) m_fifo.push_back({l, r});
      else if (m_ovf < 65535) m_ovf++;
    end
    if (clr) begin
      m_ovf = 0;
      m_unf = 0;
    end
    if (!m_run && pre >= DEPTH / 2)   m_run = 1'b1;
    else if (m_run && req && pre == 0) m_run = 1'b0;
    @(posedge clk);
    #1;
    if (pop) m_out = exp_q.pop_front();
    check_all();
  endtask

  // Reset with live strobes held high; everything must clear on the first edge.
  task automatic do_reset();
    reset_n     = 1'b0;
    in_valid    = 1'b1;
    frame_req   = 1'b1;
    clear_stats = 1'b0;
    in_left     = 16'hDEAD;
    in_right    = 16'hBEEF;
    @(posedge clk);
    #1;
    chk("rst_out_left", 32'(out_left), 32'h0);
    chk("rst_out_right", 32'(out_right), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_running", 32'(running), 32'h0);
    chk("rst_ovf", 32'(overflow_count), 32'h0);
    chk("rst_unf", 32'(underflow_count), 32'h0);
    @(posedge clk);
    #1;
    model_clear();
    reset_n   = 1'b1;
    in_valid  = 1'b0;
    frame_req = 1'b0;
  endtask

  initial begin
    reset_n     = 1'b0;
    in_valid    = 1'b0;
    frame_req   = 1'b0;
    clear_stats = 1'b0;
    in_left     = '0;
    in_right    = '0;
    model_clear();

    // prefill: 8 pushes with ignored requests, one more request still in
    // FILLING, then 8 pops in push order
    for (int i = 0; i < 8; i++) begin
      tbl[i].v   = 1'b1;
      tbl[i].l   = 16'(i + 1);
      tbl[i].r   = 16'(32'h8001 + i);
      tbl[i].req = (i % 2 == 0);
      tbl[i].lvl = i + 1;
      tbl[i].run = 1'b0;
      tbl[i].out = 32'h0;
    end
    tbl[8].v   = 1'b0;
    tbl[8].l   = 16'h0;
    tbl[8].r   = 16'h0;
    tbl[8].req = 1'b1;
    tbl[8].lvl = 8;
    tbl[8].run = 1'b1;
    tbl[8].out = 32'h0;
    for (int k = 0; k < 8; k++) begin
      tbl[9+k].v   = 1'b0;
      tbl[9+k].l   = 16'h0;
      tbl[9+k].r   = 16'h0;
      tbl[9+k].req = 1'b1;
      tbl[9+k].lvl = 7 - k;
      tbl[9+k].run = 1'b1;
      tbl[9+k].out = {16'(k + 1), 16'(32'h8001 + k)};
    end

    do_reset();

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].v, tbl[i].l, tbl[i].r, tbl[i].req, 1'b0);
      chk($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].lvl));
      chk($sformatf("tbl%0d_running", i), 32'(running), 32'(tbl[i].run));
      chk($sformatf("tbl%0d_out", i), {out_left, out_right}, tbl[i].out);
    end

    // underflow in RUNNING at level 0
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("unf_count", 32'(underflow_count), 32'd1);
    chk("unf_running", 32'(running), 32'd0);
    chk("unf_hold", {out_left, out_right}, 32'h00088008);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("unf_filling_ignores", 32'(underflow_count), 32'd1);

    // overflow: 18 pushes, no requests
    for (int i = 0; i < 18; i++)
      step(1'b1, 16'(32'h1000 + i), 16'(32'h2000 + i), 1'b0, 1'b0);
    chk("ovf_level", 32'(level), 32'd16);
    chk("ovf_count", 32'(overflow_count), 32'd2);

    // full-buffer push+pop, wrapping both pointers past 0
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 16'(32'h3000 + i), 16'(32'h4000 + i), 1'b1, 1'b0);
      if (i == 0) chk("wrap_first_out", {out_left, out_right}, 32'h10002000);
    end
    chk("wrap_level", 32'(level), 32'd16);
    chk("wrap_ovf", 32'(overflow_count), 32'd2);

    // drain, then push+request when empty
    for (int i = 0; i < 16; i++) step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("drain_level", 32'(level), 32'd0);
    step(1'b1, 16'h5555, 16'hAAAA, 1'b1, 1'b0);
    chk("empty_push_unf", 32'(underflow_count), 32'd2);
    chk("empty_push_level", 32'(level), 32'd1);
    chk("empty_push_running", 32'(running), 32'd0);

    // clear_stats coincident with an overflow
    for (int i = 0; i < 15; i++)
      step(1'b1, 16'(32'h6000 + i), 16'(32'h7000 + i), 1'b0, 1'b0);
    step(1'b1, 16'h6FFF, 16'h7FFF, 1'b0, 1'b1);
    chk("clr_ovf", 32'(overflow_count), 32'd0);
    chk("clr_unf", 32'(underflow_count), 32'd0);
    step(1'b1, 16'h6EEE, 16'h7EEE, 1'b0, 1'b0);
    chk("post_clr_ovf", 32'(overflow_count), 32'd1);

    // reset mid-stream with a full buffer; stale frames must be gone
    do_reset();
    for (int i = 0; i < 8; i++)
      step(1'b1, 16'(32'hA000 + i), 16'(32'hB000 + i), 1'b0, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("post_rst_first", {out_left, out_right}, 32'hA000B000);

    // random soak with alternating fill/drain bias
    for (int i = 0; i < 800; i++) begin
      int pv;
      pv = ((i / 60) % 2 == 0) ? 75 : 30;
      step($urandom_range(0, 99) < pv, 16'($urandom), 16'($urandom),
           $urandom_range(0, 99) < 50, $urandom_range(0, 63) == 0);
    end

    in_valid    = 1'b0;
    frame_req   = 1'b0;
    clear_stats = 1'b0;
    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
